imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Write side of the instruction ROM: streams 32-bit instruction words in over a
//  valid/ready handshake and writes them to consecutive ROM addresses. Holds the
//  pipeline (PC, IF_ID, ID_EX, EX_MEM, MEM_WB) until the last word is committed,
//  then releases it so fetch starts at BASE_ADDR. Replaces file-based ROM preload.
// PARAMETERS
//  ADDR_W     8    ROM address width (matches PC/ROM)
//  DATA_W     32   instruction word width
//  DEPTH      256  ROM words; must be <= 2**ADDR_W
//  BASE_ADDR  0    first ROM address written after reset or reload
// PORTS
//  clk        in   1       rising-edge clock
//  R          in   1       asynchronous reset, active-low
//  in_valid   in   1       source presents in_word
//  in_ready   out  1       loader accepts in_word this cycle
//  in_word    in   DATA_W  instruction word
//  in_last    in   1       marks final word of image (qualified by in_valid)
//  reload     in   1       1-cycle pulse: restart load from BASE_ADDR (DONE/ERR only)
//  wr_en      out  1       ROM write strobe
//  wr_addr    out  ADDR_W  ROM write address
//  wr_data    out  DATA_W  ROM write data
//  cpu_hold   out  1       1 = pipeline held in reset / LE=0
//  load_done  out  1       image fully written
//  overflow   out  1       image exceeded DEPTH words
//  word_count out  ADDR_W+1 words written in current load
//  checksum   out  DATA_W  (IMEM_CHKSUM_EN only) running sum of written words
// BEHAVIOUR
//  - Reset (R=0, async): state=LOAD, in_ready=1, wr_en=0, wr_addr=BASE_ADDR,
//    wr_data=0, cpu_hold=1, load_done=0, overflow=0, word_count=0, checksum=0.
//  - States: LOAD -> DONE on accepted in_last; LOAD -> ERR on accepted non-last
//    word at address BASE_ADDR+DEPTH-1; DONE/ERR -> LOAD on reload; else hold.
//  - Handshake: transfer when in_valid&&in_ready. in_ready=1 only in LOAD.
//    in_word/in_last ignored when in_valid=0.
//  - Write latency 1: transfer at edge N -> wr_en=1, wr_addr=current ptr,
//    wr_data=in_word for cycle after edge N; wr_en=0 otherwise. ptr increments
//    after each transfer; word_count increments with it.
//  - Full: word at last address is still written; if not in_last, next state ERR,
//    overflow=1, cpu_hold stays 1, in_ready=0. No wrap-around; no further writes.
//  - DONE: cpu_hold=0 and load_done=1 registered the cycle after the last write
//    strobe (never same cycle), so fetch never sees a partially written word.
//  - reload in DONE/ERR: next cycle cpu_hold=1, load_done=0, overflow=0,
//    ptr=BASE_ADDR, word_count=0, checksum=0, in_ready=1. reload in LOAD ignored.
//  - in_valid&&in_last with reload same cycle in LOAD: transfer wins, reload ignored.
//  - Reset mid-load: all outputs return to reset values immediately; ROM contents
//    already written are not cleared.
//  - Arithmetic: ptr ADDR_W bits; word_count ADDR_W+1 bits (DEPTH=256 fits).
// CONFIGURATION
//  IMEM_CHKSUM_EN defined: checksum port present; checksum += in_word (mod 2**DATA_W)
//    on each transfer, updated with wr_en; frozen in DONE/ERR, cleared on reload.
//  Not defined: checksum port and adder absent; all other behaviour identical.
// TESTING
//  1 Reset, send 0xE3A01005,0xE2811001,0xEAFFFFFE (last on 3rd) -> writes @0,1,2,
//    word_count=3, load_done=1 and cpu_hold=0 one cycle after 3rd wr_en.
//  2 in_valid toggled 1/0 every cycle, 4 words -> exactly 4 wr_en pulses, addresses
//    0..3 contiguous, no duplicates or drops.
//  3 Stream 257 words, none last -> 256 writes (0..255), overflow=1, in_ready=0,
//    cpu_hold=1, 257th word not written.
//  4 After test 1, pulse reload, send 1 word 0x00000001 last -> write @0,
//    word_count=1, load_done=1; reload pulsed during LOAD has no effect.
//  5 Assert R=0 after 2nd of 5 words -> all outputs at reset values same cycle;
//    reload stream starts again at address 0.
//  6 IMEM_CHKSUM_EN: words 0xFFFFFFFF,0x00000002 -> checksum=0x00000001 in DONE.

Source files
------------

// File: rtl/imem_loader.sv
// Instruction ROM write-side loader: accepts words over valid/ready, writes them to
// consecutive ROM addresses and holds the CPU until the image is complete.
// Optional running checksum output when IMEM_CHKSUM_EN is defined.
module imem_loader #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned DEPTH     = 256,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_word_i,
    input  logic              in_last_i,
    input  logic              reload_i,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic              cpu_hold_o,
    output logic              load_done_o,
    output logic              overflow_o,
`ifdef IMEM_CHKSUM_EN
    output logic [DATA_W-1:0] checksum_o,
`endif
    output logic [ADDR_W:0]   word_count_o
);

    localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(BASE_ADDR + DEPTH - 1);

    typedef enum logic [1:0] {StLoad, StDone, StErr} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                hold_q, hold_d;
    logic                done_q, done_d;
    logic                ovf_q, ovf_d;
`ifdef IMEM_CHKSUM_EN
    logic [DATA_W-1:0]   chk_q, chk_d;
`endif
    logic                xfer;

    assign in_ready_o = (state_q == StLoad);
    assign xfer       = in_valid_i && in_ready_o;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        count_d   = count_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        hold_d    = hold_q;
        done_d    = done_q;
        ovf_d     = ovf_q;
`ifdef IMEM_CHKSUM_EN
        chk_d     = chk_q;
`endif
        unique case (state_q)
            StLoad: begin
                // A transfer takes priority; reload has no meaning while loading.
                if (xfer) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = ptr_q;
                    wr_data_d = in_word_i;
                    ptr_d     = ptr_q + ADDR_W'(1);
                    count_d   = count_q + (ADDR_W + 1)'(1);
`ifdef IMEM_CHKSUM_EN
                    chk_d     = chk_q + in_word_i;
`endif
                    if (in_last_i) begin
                        state_d = StDone;
                    end else if (ptr_q == LastAddr) begin
                        state_d = StErr;
                        ovf_d   = 1'b1;
                    end
                end
            end
            StDone, StErr: begin
                if (reload_i) begin
                    state_d = StLoad;
                    ptr_d   = BaseAddr;
                    count_d = '0;
                    hold_d  = 1'b1;
                    done_d  = 1'b0;
                    ovf_d   = 1'b0;
`ifdef IMEM_CHKSUM_EN
                    chk_d   = '0;
`endif
                end else if (state_q == StDone) begin
                    // Released one cycle after the final write strobe.
                    hold_d = 1'b0;
                    done_d = 1'b1;
                end
            end
            default: state_d = StLoad;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StLoad;
            ptr_q     <= BaseAddr;
            count_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= BaseAddr;
            wr_data_q <= '0;
            hold_q    <= 1'b1;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
`ifdef IMEM_CHKSUM_EN
            chk_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            count_q   <= count_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            hold_q    <= hold_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
`ifdef IMEM_CHKSUM_EN
            chk_q     <= chk_d;
`endif
        end
    end

    assign wr_en_o      = wr_en_q;
    assign wr_addr_o    = wr_addr_q;
    assign wr_data_o    = wr_data_q;
    assign cpu_hold_o   = hold_q;
    assign load_done_o  = done_q;
    assign overflow_o   = ovf_q;
    assign word_count_o = count_q;
`ifdef IMEM_CHKSUM_EN
    assign checksum_o   = chk_q;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: driver pushes expected ROM writes from an
// image-level model, a negedge monitor pops and compares every write strobe.
module tb_imem_loader;

    localparam int ADDR_W    = 8;
    localparam int DATA_W    = 32;
    localparam int DEPTH     = 256;
    localparam int BASE_ADDR = 0;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              in_valid_i = 1'b0;
    logic              in_ready_o;
    logic [DATA_W-1:0] in_word_i = '0;
    logic              in_last_i = 1'b0;
    logic              reload_i = 1'b0;
    logic              wr_en_o;
    logic [ADDR_W-1:0] wr_addr_o;
    logic [DATA_W-1:0] wr_data_o;
    logic              cpu_hold_o;
    logic              load_done_o;
    logic              overflow_o;
    logic [ADDR_W:0]   word_count_o;
`ifdef IMEM_CHKSUM_EN
    logic [DATA_W-1:0] checksum_o;
`endif

    imem_loader #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .BASE_ADDR(BASE_ADDR)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_word_i   (in_word_i),
        .in_last_i   (in_last_i),
        .reload_i    (reload_i),
        .wr_en_o     (wr_en_o),
        .wr_addr_o   (wr_addr_o),
        .wr_data_o   (wr_data_o),
        .cpu_hold_o  (cpu_hold_o),
        .load_done_o (load_done_o),
        .overflow_o  (overflow_o),
`ifdef IMEM_CHKSUM_EN
        .checksum_o  (checksum_o),
`endif
        .word_count_o(word_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    // Image-level model: words accepted so far and the phase of the current load.
    bit          m_loading  = 1'b1;
    bit          m_finished = 1'b0;
    bit          m_full     = 1'b0;
    int          m_n        = 0;
    logic [31:0] m_chk      = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_i) begin
        if (rst_ni && wr_en_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got addr=%0h data=%h expected none",
                         wr_addr_o, wr_data_o);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (wr_addr_o !== e.addr || wr_data_o !== e.data) begin
                    errors++;
                    $display("FAIL rom_write got addr=%0h data=%h expected addr=%0h data=%h",
                             wr_addr_o, wr_data_o, e.addr, e.data);
                end
            end
        end
    end

    // Called at a negedge; returns at the following negedge.
    task automatic drive_cycle(input bit v, input logic [31:0] w, input bit l, input bit rel);
        in_valid_i = v;
        in_word_i  = w;
        in_last_i  = l;
        reload_i   = rel;
        chk("in_ready", 64'(in_ready_o), 64'(m_loading));
        @(posedge clk_i);
        if (v && m_loading) begin
            exp_q.push_back('{addr: ADDR_W'(BASE_ADDR + m_n), data: w});
            m_n++;
            m_chk = m_chk + w;
            if (l) begin
                m_loading  = 1'b0;
                m_finished = 1'b1;
            end else if (m_n == DEPTH) begin
                m_loading = 1'b0;
                m_full    = 1'b1;
            end
        end else if (rel && !m_loading) begin
            m_loading  = 1'b1;
            m_finished = 1'b0;
            m_full     = 1'b0;
            m_n        = 0;
            m_chk      = '0;
        end
        @(negedge clk_i);
        in_valid_i = 1'b0;
        reload_i   = 1'b0;
    endtask

    task automatic idle();
        drive_cycle(1'b0, $urandom, 1'($urandom), 1'b0);
    endtask

    task automatic check_status(input string tag);
        chk({tag, "_load_done"}, 64'(load_done_o), 64'(m_finished));
        chk({tag, "_cpu_hold"}, 64'(cpu_hold_o), 64'(!m_finished));
        chk({tag, "_overflow"}, 64'(overflow_o), 64'(m_full));
        chk({tag, "_word_count"}, 64'(word_count_o), 64'(m_n));
        chk({tag, "_pending_writes"}, 64'(exp_q.size()), 64'(0));
`ifdef IMEM_CHKSUM_EN
        chk({tag, "_checksum"}, 64'(checksum_o), 64'(m_chk));
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready_o), 64'(1));
        chk({tag, "_wr_en"}, 64'(wr_en_o), 64'(0));
        chk({tag, "_wr_addr"}, 64'(wr_addr_o), 64'(BASE_ADDR));
        chk({tag, "_wr_data"}, 64'(wr_data_o), 64'(0));
        chk({tag, "_cpu_hold"}, 64'(cpu_hold_o), 64'(1));
        chk({tag, "_load_done"}, 64'(load_done_o), 64'(0));
        chk({tag, "_overflow"}, 64'(overflow_o), 64'(0));
        chk({tag, "_word_count"}, 64'(word_count_o), 64'(0));
`ifdef IMEM_CHKSUM_EN
        chk({tag, "_checksum"}, 64'(checksum_o), 64'(0));
`endif
    endtask

    // Random-gap stream of len words; optional last flag on the final word and
    // occasional reload pulses that must be ignored while loading.
    task automatic send_stream(input int len, input bit last_at_end);
        for (int i = 0; i < len; i++) begin
            while ($urandom_range(0, 3) == 0)
                drive_cycle(1'b0, $urandom, 1'($urandom), 1'($urandom_range(0, 4) == 0));
            drive_cycle(1'b1, $urandom, last_at_end && (i == len - 1),
                        1'($urandom_range(0, 5) == 0));
        end
    endtask

    initial begin
        logic [31:0] img [3];
        img[0] = 32'hE3A01005;
        img[1] = 32'hE2811001;
        img[2] = 32'hEAFFFFFE;

        @(negedge clk_i);
        check_reset_outputs("reset");
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Three-word image; release exactly one cycle after the last strobe.
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, img[i], i == 2, 1'b0);
        chk("t1_wr_en_last", 64'(wr_en_o), 64'(1));
        chk("t1_done_not_early", 64'(load_done_o), 64'(0));
        chk("t1_hold_not_early", 64'(cpu_hold_o), 64'(1));
        idle();
        chk("t1_done", 64'(load_done_o), 64'(1));
        chk("t1_hold", 64'(cpu_hold_o), 64'(0));
        chk("t1_wr_en_off", 64'(wr_en_o), 64'(0));
        check_status("t1");

        // Reload, ignored reload in LOAD, then last word with a coincident reload.
        drive_cycle(1'b0, '0, 1'b0, 1'b1);
        check_status("t4_reload");
        drive_cycle(1'b0, '0, 1'b0, 1'b1);
        drive_cycle(1'b1, 32'h00000001, 1'b1, 1'b1);
        idle();
        check_status("t4");

        // Valid toggled every cycle.
        drive_cycle(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, $urandom, i == 3, 1'b0);
            drive_cycle(1'b0, $urandom, 1'b1, 1'b0);
        end
        idle();
        check_status("t2");

        // Randomized loads with gaps and spurious reloads.
        for (int r = 0; r < 6; r++) begin
            drive_cycle(1'b0, '0, 1'b0, 1'b1);
            send_stream($urandom_range(1, 20), 1'b1);
            idle();
            check_status("rand");
        end

        // Overflow: 257 non-last words.
        drive_cycle(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH + 1; i++) drive_cycle(1'b1, $urandom, 1'b0, 1'b0);
        idle();
        check_status("t3");
        chk("t3_overflow_set", 64'(overflow_o), 64'(1));
        drive_cycle(1'b1, $urandom, 1'b1, 1'b0);
        idle();
        check_status("t3_frozen");
        drive_cycle(1'b0, '0, 1'b0, 1'b1);
        check_status("t3_reload");
        send_stream(3, 1'b1);
        idle();
        check_status("t3_after");

        // Asynchronous reset mid-load after the 2nd of 5 words.
        drive_cycle(1'b0, '0, 1'b0, 1'b1);
        drive_cycle(1'b1, $urandom, 1'b0, 1'b0);
        drive_cycle(1'b1, $urandom, 1'b0, 1'b0);
        #2 rst_ni = 1'b0;
        #1 check_reset_outputs("t5");
        chk("t5_pending_writes", 64'(exp_q.size()), 64'(0));
        m_loading = 1'b1; m_finished = 1'b0; m_full = 1'b0; m_n = 0; m_chk = '0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        send_stream(5, 1'b1);
        idle();
        check_status("t5_after");

`ifdef IMEM_CHKSUM_EN
        drive_cycle(1'b0, '0, 1'b0, 1'b1);
        drive_cycle(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
        drive_cycle(1'b1, 32'h00000002, 1'b1, 1'b0);
        idle();
        chk("t6_checksum", 64'(checksum_o), 64'h1);
        idle();
        check_status("t6_frozen");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
